// File: rtl/block_out_ser_if.sv
// ---------------------------------------------------------------------------
// block_out_ser_if
// Bus bundle for the output serializer. It carries two channels:
//   block side (from flow_cntr):
//     block_in      [BLOCK_W] result block, held stable until accepted
//     block_in_vld            block valid
//     block_accept            one-cycle accept pulse back to flow_cntr
//   word side (toward chip I/O):
//     word_out      [WORD_W]  current output word
//     word_out_vld            word valid
//     word_out_rdy            consumer ready
//     word_last               high with the final word of a block
// The master modport is the serializer's view of the bus. The slave modport
// is the view of the surrounding logic that drives blocks and consumes words.
// ---------------------------------------------------------------------------
interface block_out_ser_if #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128
);
    logic [BLOCK_W-1:0] block_in;
    logic               block_in_vld;
    logic               block_accept;
    logic [WORD_W-1:0]  word_out;
    logic               word_out_vld;
    logic               word_out_rdy;
    logic               word_last;

    modport master (
        input  block_in, block_in_vld, word_out_rdy,
        output block_accept, word_out, word_out_vld, word_last
    );

    modport slave (
        output block_in, block_in_vld, word_out_rdy,
        input  block_accept, word_out, word_out_vld, word_last
    );
endinterface

// File: rtl/block_out_ser.sv
// ---------------------------------------------------------------------------
// block_out_ser
// Takes one 128-bit result block from flow_cntr and sends it out as four
// 32-bit words, most-significant word first, on a valid/ready bus. The next
// block is taken in the same cycle that the last word leaves, so a steady
// stream of blocks keeps the output bus busy on every cycle.
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; discards any partially sent block
//   bus      if   block_out_ser_if.master (block and word channels)
//   busy     out  a block is held and being sent
//   blk_cnt  out  [CNT_W] blocks fully sent since reset; wraps around
// ---------------------------------------------------------------------------
module block_out_ser #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    block_out_ser_if.master  bus,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BLOCK_W-1:0] r_hold;
    logic [1:0]         r_widx;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic               w_send;
    logic               w_wfire;
    logic               w_lfire;
    logic               w_accept;
    logic [WORD_W-1:0]  w_word;

    // Next state, handshakes and word select
    always_comb begin
        w_state_nxt = r_state;
        w_send      = (r_state == SEND);
        w_wfire     = w_send && bus.word_out_rdy;
        w_lfire     = w_wfire && (r_widx == 2'd3);
        // A block can be taken when nothing is held, or when the last word
        // of the held block leaves in this very cycle. Reset wins.
        w_accept    = bus.block_in_vld && (!w_send || w_lfire) && !reset;

        if (w_accept) begin
            w_state_nxt = SEND;
        end else if (w_lfire) begin
            w_state_nxt = IDLE;
        end

        // The word bus reads zero whenever no block is being sent.
        w_word = '0;
        if (w_send) begin
            case (r_widx)
                2'd0:    w_word = r_hold[BLOCK_W-1 -: WORD_W];
                2'd1:    w_word = r_hold[BLOCK_W-1-WORD_W -: WORD_W];
                2'd2:    w_word = r_hold[BLOCK_W-1-2*WORD_W -: WORD_W];
                default: w_word = r_hold[WORD_W-1:0];
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Held block, word index and completed-block counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_widx    <= '0;
            r_blk_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_hold <= bus.block_in;
                r_widx <= '0;
            end else if (w_lfire) begin
                r_widx <= '0;
            end else if (w_wfire) begin
                r_widx <= r_widx + 2'd1;
            end
            if (w_lfire) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    assign bus.block_accept = w_accept;
    assign bus.word_out     = w_word;
    assign bus.word_out_vld = w_send;
    assign bus.word_last    = w_send && (r_widx == 2'd3);
    assign busy             = w_send;
    assign blk_cnt          = r_blk_cnt;
endmodule

// File: tb/tb_block_out_ser.sv
// ---------------------------------------------------------------------------
// tb_block_out_ser
// Bench for block_out_ser. Words expected from each accepted block are
// queued when the block is taken and popped as words leave the DUT. A small
// vector table drives single blocks with optional stalls. Hand-written
// sequences cover reset, idle hold, back-to-back blocks, reset in the middle
// of a block and counter wrap.
// ---------------------------------------------------------------------------
module tb_block_out_ser;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    block_out_ser_if #(.WORD_W(32), .BLOCK_W(128)) bus ();

    block_out_ser #(
        .WORD_W (32),
        .BLOCK_W(128),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .busy   (busy),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]      blk;
        int                stall_w;   // word index that sees back-pressure, -1 none
        int                stall_n;   // number of stalled cycles
        int                exp_busy;  // busy cycles from capture to IDLE
        logic [0:3][31:0]  w;         // expected words in order
    } vec_t;

    int               checks   = 0;
    int               failures = 0;
    logic [32:0]      sb_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    int               n_done = 0;

    logic             o_acc, o_vld, o_wfire, o_last, o_busy;
    logic [31:0]      o_word;
    logic [CNT_W-1:0] o_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs were set by the caller after a falling edge.
    // Sample just after, update the model, then move to the next falling edge.
    task automatic step();
        logic [32:0] e;
        #2;
        o_acc   = bus.block_accept;
        o_vld   = bus.word_out_vld;
        o_wfire = bus.word_out_vld && bus.word_out_rdy;
        o_last  = bus.word_last;
        o_word  = bus.word_out;
        o_busy  = busy;
        o_cnt   = blk_cnt;
        if (reset) chk("acc_during_reset", o_acc, 1'b0);
        chk("sb_blk_cnt", o_cnt, m_cnt);
        if (o_wfire) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_word: got %0h expected no word", o_word);
            end else begin
                e = sb_q.pop_front();
                chk("sb_word", o_word, e[31:0]);
                chk("sb_last", o_last, e[32]);
                if (e[32]) begin
                    m_cnt++;
                    n_done++;
                end
            end
        end
        if (reset) begin
            sb_q.delete();
            m_cnt = '0;
        end else if (o_acc) begin
            sb_q.push_back({1'b0, bus.block_in[127:96]});
            sb_q.push_back({1'b0, bus.block_in[95:64]});
            sb_q.push_back({1'b0, bus.block_in[63:32]});
            sb_q.push_back({1'b1, bus.block_in[31:0]});
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int               sent;
        int               stalls;
        int               nb;
        logic [CNT_W-1:0] c1;
        sent   = 0;
        stalls = v.stall_n;
        nb     = 0;
        c1     = m_cnt + 1'b1;
        bus.block_in     = v.blk;
        bus.block_in_vld = 1'b1;
        bus.word_out_rdy = 1'b1;
        step();
        chk("tbl_accept", o_acc, 1'b1);
        bus.block_in_vld = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sent == v.stall_w && stalls > 0) begin
                bus.word_out_rdy = 1'b0;
                stalls--;
            end else begin
                bus.word_out_rdy = 1'b1;
            end
            step();
            if (k == 0) chk("tbl_word0_valid", o_vld, 1'b1);
            if (o_acc) chk("tbl_no_accept", o_acc, 1'b0);
            if (o_vld && !bus.word_out_rdy && sent < 4) begin
                chk("tbl_stall_word", o_word, v.w[sent]);
                chk("tbl_stall_last", o_last, sent == 3);
            end
            if (o_wfire && sent < 4) begin
                chk("tbl_word", o_word, v.w[sent]);
                chk("tbl_last", o_last, sent == 3);
                sent++;
            end
            if (o_busy) nb++;
            else break;
        end
        chk("tbl_busy_cycles", nb, v.exp_busy);
        chk("tbl_words_sent", sent, 4);
        chk("tbl_blk_cnt", o_cnt, c1);
        bus.word_out_rdy = 1'b1;
    endtask

    initial begin
        vec_t vt[4];
        logic [127:0]     blk_a, blk_b;
        logic [CNT_W-1:0] c2;
        int               nv, nacc, acc_k, last_k, k_blk, pre;
        bit               c255, c256;

        vt[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, -1, 0, 4,
                  {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}};
        vt[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1, 3, 7,
                  {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}};
        vt[2] = '{128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 3, 2, 6,
                  {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}};
        vt[3] = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000001, 0, 1, 5,
                  {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001}};

        // Reset, with a block offered during reset that must not be accepted
        reset            = 1'b1;
        bus.block_in     = vt[0].blk;
        bus.block_in_vld = 1'b1;
        bus.word_out_rdy = 1'b1;
        @(negedge clk);
        step();
        reset            = 1'b0;
        bus.block_in_vld = 1'b0;
        step();
        chk("rst_accept", o_acc, 1'b0);
        chk("rst_word_out", o_word, 32'h0);
        chk("rst_vld", o_vld, 1'b0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_blk_cnt", o_cnt, 8'd0);

        // Idle hold
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_vld", o_vld, 1'b0);
            chk("idle_accept", o_acc, 1'b0);
            chk("idle_busy", o_busy, 1'b0);
        end

        // Table: single blocks with and without back-pressure
        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        // Back-to-back: B valid throughout A's transfer
        blk_a = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
        blk_b = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
        c2    = m_cnt + 2'd2;
        bus.block_in     = blk_a;
        bus.block_in_vld = 1'b1;
        step();
        chk("b2b_accept_a", o_acc, 1'b1);
        bus.block_in = blk_b;
        nv = 0; nacc = 0; acc_k = -1; last_k = -2;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_vld) nv++;
            if (o_wfire && o_last && last_k == -2) last_k = k;
            if (o_acc) begin
                nacc++;
                acc_k = k;
                bus.block_in_vld = 1'b0;
            end
            if (!o_busy) break;
        end
        chk("b2b_accept_count", nacc, 1);
        chk("b2b_accept_on_last", acc_k, last_k);
        chk("b2b_valid_cycles", nv, 8);
        chk("b2b_blk_cnt", o_cnt, c2);

        // Reset after word 1 has been sent
        bus.block_in     = vt[2].blk;
        bus.block_in_vld = 1'b1;
        step();
        chk("mid_accept", o_acc, 1'b1);
        bus.block_in_vld = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_accept", o_acc, 1'b0);
        chk("mid_rst_word", o_word, 32'h0);
        chk("mid_rst_vld", o_vld, 1'b0);
        chk("mid_rst_last", o_last, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_blk_cnt", o_cnt, 8'd0);
        run_vec(vt[0]);

        // Counter wrap over 256 back-to-back blocks
        reset = 1'b1;
        step();
        reset  = 1'b0;
        n_done = 0;
        k_blk  = 0;
        c255   = 1'b0;
        c256   = 1'b0;
        bus.word_out_rdy = 1'b1;
        bus.block_in     = {4{32'(k_blk) ^ 32'h5A5A0000}};
        bus.block_in_vld = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            pre = n_done;
            step();
            if (o_acc) begin
                k_blk++;
                if (k_blk >= 256) bus.block_in_vld = 1'b0;
                else bus.block_in = {4{32'(k_blk) ^ 32'h5A5A0000}};
            end
            if (pre == 255 && !c255) begin
                chk("wrap_cnt_255", o_cnt, 8'd255);
                c255 = 1'b1;
            end
            if (pre == 256) begin
                chk("wrap_cnt_0", o_cnt, 8'd0);
                c256 = 1'b1;
                break;
            end
        end
        chk("wrap_reached", {c255, c256}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/block_out_ser.md
# block_out_ser

Output serializer sitting directly downstream of `flow_cntr`. It accepts each finished 128-bit AES result block over the `data_out` / `data_out_vld` / `data_accept` handshake. It emits the block as four 32-bit words on a valid/ready bus toward the chip I/O, and can accept the next block in the same cycle its last word leaves, so the output bus runs at one word per cycle.

## Interface
Parameters:
- `WORD_W`, 32: output word width; fixed at 32.
- `BLOCK_W`, 128: block width; fixed at 128 (4 words).
- `CNT_W`, 8: width of the completed-block counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `block_in`  in  128  result block; connects to `flow_cntr.data_out`.
- `block_in_vld`  in  1  block valid; connects to `flow_cntr.data_out_vld`. Held high with stable data until accepted.
- `block_accept`  out  1  one-cycle accept pulse; connects to `flow_cntr.data_accept`.
- `word_out`  out  32  current output word.
- `word_out_vld`  out  1  `word_out` valid.
- `word_out_rdy`  in  1  consumer ready.
- `word_last`  out  1  high with the 4th word of a block.
- `busy`  out  1  a block is held (state `SEND`).
- `blk_cnt`  out  `CNT_W`  completed blocks since reset; wraps.

## Operation
- State machine with two states:
  - `IDLE`: no block held.
  - `SEND`: block held in a 128-bit register `hold`, with a 2-bit word index `widx`.
- Handshake definitions:
  - `wfire` = `word_out_vld && word_out_rdy`.
  - `lfire` = `wfire && widx==3`.
- `block_accept` (combinational) = `block_in_vld && (state==IDLE || lfire)`.
- Capture on `block_accept`: `hold <= block_in`, `widx <= 0`, state -> `SEND`.
- Word order is most-significant first:
  - word 0 = `hold[127:96]`, word 1 = `[95:64]`, word 2 = `[63:32]`, word 3 = `[31:0]`.
- `word_out` = `hold` slice selected by `widx`.
- `word_out_vld` = (state==SEND).
- `word_last` = (state==SEND && widx==3).
- On `wfire` with `widx<3`: `widx` increments.
- On `lfire`:
  - `blk_cnt` increments, wrapping from 2^CNT_W−1 to 0.
  - If `block_accept` is high in the same cycle, capture the new block (back-to-back).
  - Otherwise state -> `IDLE`.
- `busy` = (state==SEND).
- Back-pressure:
  - While `word_out_vld && !word_out_rdy`, `word_out`, `word_last` and `widx` hold.
  - No new block is accepted while in `SEND` except on `lfire`.
- `block_in_vld` low in `IDLE`: remain in `IDLE`, outputs idle.
- Reset:
  - State -> `IDLE`, `widx` = 0, `hold` = 0, `blk_cnt` = 0.
  - Any partially sent block is discarded.
  - `block_accept` is forced 0 during the reset cycle.

## Timing
- Reset values: `block_accept`=0, `word_out`=0, `word_out_vld`=0, `word_last`=0, `busy`=0, `blk_cnt`=0.
- Accept latency:
  - With `block_in_vld` rising in `IDLE`, `block_accept` is high in the same cycle (cycle N), and capture is at the end of cycle N.
  - Word 0 is valid in cycle N+1.
  - `flow_cntr` drops or updates `block_in_vld` after seeing `block_accept` at edge N.
- Throughput:
  - With `word_out_rdy` held high, words 0..3 appear in cycles N+1..N+4, and `word_last` is high in N+4.
  - A pending next block is accepted in N+4, and its word 0 appears in N+5, with no bubble.
- `block_accept` is never high for more than one cycle per block, and never while `reset` is high.
- Reset asserted mid-block: outputs reach their reset values in the cycle after the reset edge.
- `blk_cnt` updates in the cycle after `lfire`.

## Test plan
- Single block, `word_out_rdy`=1:
  - Stimulus: `block_in`=0x00112233_44556677_8899AABB_CCDDEEFF, valid in cycle 1.
  - Response: `block_accept` pulses in cycle 1; `word_out` = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF in cycles 2–5; `word_last` is high only in cycle 5; `blk_cnt` reads 1 in cycle 6; `busy` reads 0 in cycle 6.
- Back-pressure:
  - Stimulus: same block, with `word_out_rdy` low for 3 cycles during word 1.
  - Response: `word_out` holds 0x44556677 with `vld` high; no `block_accept` pulse; total 7 cycles from capture to return to `IDLE`.
- Back-to-back:
  - Stimulus: two blocks A and B, with B's valid high throughout A's transfer.
  - Response: B is accepted in the same cycle as A's `word_last`; B word 0 appears the next cycle; 8 consecutive valid cycles; `blk_cnt`=2.
- Reset mid-block:
  - Stimulus: assert `reset` after word 1 has been sent.
  - Response: next cycle all outputs at reset values and `blk_cnt`=0; a new block afterward is serialized from word 0.
- Counter wrap:
  - Stimulus: 256 blocks with `CNT_W`=8.
  - Response: `blk_cnt` reads 255 after block 255, then 0 after block 256.
- Idle hold:
  - Stimulus: `block_in_vld`=0 for 20 cycles after reset.
  - Response: `word_out_vld`=0, `block_accept`=0, `busy`=0 throughout.
